// File: rtl/i2c_tgt_pkg.sv
// Shared types for the I2C register target: FSM states, bus bit constants, helper.
// No logic of its own; imported by i2c_tgt_sync and i2c_target_regs.
// No flow control; pure declarations.
package i2c_tgt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

  // Level of SDA on the 9th bit: low acknowledges, high (released) refuses
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Bit counter must hold 0..8
  localparam int BCW = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_tgt_sync.sv
// Synchronises SCL/SDA and detects SCL edges plus START/STOP conditions.
// Latency: 2 clk sync (+2 clk with I2C_TGT_GLITCH_FILTER_EN majority filter), 1 clk edge history.
// No backpressure; edge/condition outputs are single-cycle strobes.
module i2c_tgt_sync
  import i2c_tgt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_cur;
  logic       sda_cur;
  logic       scl_prev;
  logic       sda_prev;

  // Two-flop synchronisers; idle bus level is high, so reset to 1 to avoid false edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
    end else begin
      scl_ff <= {scl_ff[0], scl_in};
      sda_ff <= {sda_ff[0], sda_in};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] scl_hist;
  logic [1:0] sda_hist;
  logic       scl_filt;
  logic       sda_filt;

  // 3-sample majority vote: a level must persist 2 clk before it is believed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_filt <= 1'b1;
      sda_filt <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_ff[1]};
      sda_hist <= {sda_hist[0], sda_ff[1]};
      scl_filt <= maj3(scl_ff[1], scl_hist[0], scl_hist[1]);
      sda_filt <= maj3(sda_ff[1], sda_hist[0], sda_hist[1]);
    end
  end

  assign scl_cur = scl_filt;
  assign sda_cur = sda_filt;
`else
  assign scl_cur = scl_ff[1];
  assign sda_cur = sda_ff[1];
`endif

  // One-cycle history of the cleaned levels for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_cur;
      sda_prev <= sda_cur;
    end
  end

  assign sda      = sda_cur;
  assign scl_rise = scl_cur & ~scl_prev;
  assign scl_fall = ~scl_cur & scl_prev;
  // SDA may only move while SCL is high for a START/STOP; SCL high on both samples
  assign start    = scl_cur & scl_prev & sda_prev & ~sda_cur;
  assign stop     = scl_cur & scl_prev & ~sda_prev & sda_cur;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing NREGS byte registers (pointer-then-data, auto-increment) plus a local port.
// Latency: bus events seen 3 clk after the pin (5 with I2C_TGT_GLITCH_FILTER_EN); loc_rdata combinational.
// No clock stretching (scl_oe tied low); I2C commit wins over a same-index local write.
module i2c_target_regs
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] TGT_ADDR = 7'h42,
  parameter int         NREGS    = 8,
  localparam int        PW       = $clog2(NREGS)
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          scl_oe,
  output logic          sda_oe,
  input  logic [PW-1:0] loc_addr,
  input  logic          loc_wr,
  input  logic [7:0]    loc_wdata,
  output logic [7:0]    loc_rdata,
  output logic          i2c_wr_pulse,
  output logic [PW-1:0] i2c_wr_idx,
  output logic          busy
);

  logic           sda_s;
  logic           scl_rise;
  logic           scl_fall;
  logic           start_det;
  logic           stop_det;
  state_t         state;
  logic [6:0]     shift;
  logic [BCW-1:0] bit_cnt;
  logic [PW-1:0]  ptr;
  logic [6:0]     tx_rest;
  logic           rw;
  logic [7:0]     regs [NREGS];
  logic [7:0]     rx_byte;
  logic           last_bit;
  logic           i2c_commit;

  i2c_tgt_sync u_sync (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start_det),
    .stop     (stop_det)
  );

  assign scl_oe     = 1'b0;
  assign loc_rdata  = regs[loc_addr];
  // Full received byte as of the current SCL rise (7 earlier bits plus the bit on the wire)
  assign rx_byte    = {shift, sda_s};
  assign last_bit   = scl_rise && (bit_cnt == BCW'(7));
  assign i2c_commit = (state == ST_WDATA) && last_bit;

  // Protocol FSM; ACK and read bits are driven from the cycle after an SCL fall
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= ST_IDLE;
      shift        <= '0;
      bit_cnt      <= '0;
      ptr          <= '0;
      tx_rest      <= '0;
      rw           <= 1'b0;
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      i2c_wr_pulse <= 1'b0;
      i2c_wr_idx   <= '0;
    end else begin
      i2c_wr_pulse <= 1'b0;
      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        if (scl_rise && (state == ST_ADDR || state == ST_PTR || state == ST_WDATA)) begin
          shift   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 1'b1;
        end
        case (state)
          ST_ADDR: begin
            if (last_bit) begin
              if (rx_byte[7:1] == TGT_ADDR) begin
                state <= ST_ADDR_ACK;
                rw    <= rx_byte[0];
                busy  <= 1'b1;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= ~I2C_ACK;
              end else begin
                bit_cnt <= '0;
                if (rw) begin
                  tx_rest <= regs[ptr][6:0];
                  sda_oe  <= ~regs[ptr][7];
                  state   <= ST_RDATA;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= ST_PTR;
                end
              end
            end
          end
          ST_PTR: begin
            if (last_bit) begin
              ptr   <= rx_byte[PW-1:0];
              state <= ST_PTR_ACK;
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= ~I2C_ACK;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_WDATA;
              end
            end
          end
          ST_WDATA: begin
            if (last_bit) begin
              i2c_wr_pulse <= 1'b1;
              i2c_wr_idx   <= ptr;
              ptr          <= ptr + 1'b1;
              state        <= ST_WDATA_ACK;
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (scl_fall) begin
              if (bit_cnt == BCW'(8)) begin
                sda_oe <= 1'b0;
                state  <= ST_RDATA_ACK;
              end else begin
                sda_oe  <= ~tx_rest[6];
                tx_rest <= {tx_rest[5:0], 1'b0};
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              ptr <= ptr + 1'b1;
              if (sda_s == I2C_NACK) begin
                state <= ST_IGNORE;
                busy  <= 1'b0;
              end
            end else if (scl_fall) begin
              // Only reached after an ACK; ptr already advanced on the ACK rise
              tx_rest <= regs[ptr][6:0];
              sda_oe  <= ~regs[ptr][7];
              bit_cnt <= '0;
              state   <= ST_RDATA;
            end
          end
          ST_IDLE, ST_IGNORE: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Register array; the I2C commit is written last so it wins a same-index collision
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (loc_wr) regs[loc_addr] <= loc_wdata;
      if (i2c_commit) regs[ptr] <= rx_byte;
    end
  end

endmodule
